// File: rtl/pc_gen.sv
// Program-counter generator for the IF stage: sequential fetch, stall hold,
// branch redirect (deferred while stalled) and flush redirect.
module pc_gen #(
  parameter int unsigned         ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0,
  parameter int unsigned         PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] new_pc_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              ce_o,
  output logic              redirect_pend_o
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);

  logic              ce_q, ce_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic [ADDR_W-1:0] flush_pc, branch_pc;

  assign flush_pc  = new_pc_i & ALIGN_MASK;
  assign branch_pc = branch_target_i & ALIGN_MASK;

  // Priority: flush > stall (capture branch) > live branch > pending > increment.
  always_comb begin
    ce_d      = 1'b1;
    pc_d      = pc_q;
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;
    if (!ce_q) begin
      pc_d      = RESET_PC;
      pend_d    = 1'b0;
      pend_pc_d = '0;
    end else if (flush_i) begin
      pc_d      = flush_pc;
      pend_d    = 1'b0;
      pend_pc_d = '0;
    end else if (stall_i) begin
      if (branch_flag_i) begin
        pend_d    = 1'b1;
        pend_pc_d = branch_pc;
      end
    end else if (branch_flag_i) begin
      pc_d      = branch_pc;
      pend_d    = 1'b0;
      pend_pc_d = '0;
    end else if (pend_q) begin
      pc_d      = pend_pc_q;
      pend_d    = 1'b0;
      pend_pc_d = '0;
    end else begin
      pc_d = pc_q + STEP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ce_q      <= 1'b0;
      pc_q      <= RESET_PC;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
    end else begin
      ce_q      <= ce_d;
      pc_q      <= pc_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  assign pc_o            = pc_q;
  assign ce_o            = ce_q;
  assign redirect_pend_o = pend_q;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed scenarios plus randomized control traffic
// checked against a cycle-level behavioural model of the fetch address.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, flush_i, branch_flag_i;
  logic [31:0] new_pc_i, branch_target_i;
  logic [31:0] pc_o;
  logic        ce_o, redirect_pend_o;

  int checks   = 0;
  int failures = 0;

  // behavioural model state
  bit          m_ce;
  bit          m_pend;
  logic [31:0] m_pc;
  logic [31:0] m_tgt;

  pc_gen dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .new_pc_i        (new_pc_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .pc_o            (pc_o),
    .ce_o            (ce_o),
    .redirect_pend_o (redirect_pend_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ce = 0; m_pend = 0; m_pc = 32'h0; m_tgt = 32'h0;
  endtask

  // One clock of the architectural rules, evaluated on the inputs being applied.
  task automatic model_step();
    logic [31:0] bt;
    bt = branch_target_i & 32'hFFFF_FFFC;
    if (!m_ce) begin
      m_ce = 1;
    end else if (flush_i) begin
      m_pc = new_pc_i & 32'hFFFF_FFFC; m_pend = 0;
    end else if (stall_i) begin
      if (branch_flag_i) begin m_pend = 1; m_tgt = bt; end
    end else if (branch_flag_i) begin
      m_pc = bt; m_pend = 0;
    end else if (m_pend) begin
      m_pc = m_tgt; m_pend = 0;
    end else begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"}, pc_o, m_pc);
    check({tag, ".ce"}, {31'd0, ce_o}, {31'd0, m_ce});
    check({tag, ".pend"}, {31'd0, redirect_pend_o}, {31'd0, m_pend});
  endtask

  // Apply inputs mid-cycle, clock once, compare 1 time unit after the edge.
  task automatic cycle(input string tag, input bit s, input bit f, input bit b,
                       input logic [31:0] np, input logic [31:0] bt);
    stall_i = s; flush_i = f; branch_flag_i = b; new_pc_i = np; branch_target_i = bt;
    model_step();
    @(posedge clk); #1;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1;
    stall_i = 0; flush_i = 0; branch_flag_i = 0; new_pc_i = '0; branch_target_i = '0;
    model_reset();
    #12;
    check_all("reset");
    rst = 1'b0;

    // T1: reset release and free run
    cycle("t1_e1", 0, 0, 0, 0, 0);
    check("t1_first_pc", pc_o, 32'h0);
    for (int i = 0; i < 3; i++) cycle("t1_run", 0, 0, 0, 0, 0);
    check("t1_pc_c", pc_o, 32'hC);

    // T2: branch from 0x10
    cycle("t2_seq", 0, 0, 0, 0, 0);
    cycle("t2_br", 0, 0, 1, 0, 32'h100);
    check("t2_target", pc_o, 32'h100);
    cycle("t2_after", 0, 0, 0, 0, 0);
    check("t2_next", pc_o, 32'h104);

    // T3: branch captured during a 3-cycle stall
    cycle("t3_flush", 0, 1, 0, 32'h20, 0);
    cycle("t3_s1", 1, 0, 0, 0, 0);
    cycle("t3_s2", 1, 0, 1, 0, 32'h200);
    cycle("t3_s3", 1, 0, 0, 0, 0);
    check("t3_held", pc_o, 32'h20);
    check("t3_pend", {31'd0, redirect_pend_o}, 32'd1);
    cycle("t3_rel", 0, 0, 0, 0, 0);
    check("t3_apply", pc_o, 32'h200);

    // T4: flush beats stall and branch
    cycle("t4", 1, 1, 1, 32'h380, 32'h40);
    check("t4_pc", pc_o, 32'h380);

    // T5: wrap and alignment
    cycle("t5_flush", 0, 1, 0, 32'hFFFF_FFF8, 0);
    cycle("t5_w1", 0, 0, 0, 0, 0);
    check("t5_fffc", pc_o, 32'hFFFF_FFFC);
    cycle("t5_w2", 0, 0, 0, 0, 0);
    check("t5_wrap", pc_o, 32'h0);
    cycle("t5_align", 0, 0, 1, 0, 32'h0000_0123);
    check("t5_align_pc", pc_o, 32'h120);
    cycle("t5_falign", 0, 1, 0, 32'h0000_0457, 0);

    // Randomized control traffic
    for (int i = 0; i < 400; i++) begin
      bit s, f, b;
      s = ($urandom_range(0, 99) < 35);
      f = ($urandom_range(0, 99) < 6);
      b = ($urandom_range(0, 99) < 25);
      cycle("rand", s, f, b, $urandom, $urandom);
    end

    // T6: async reset while a redirect is pending
    cycle("t6_cap", 1, 0, 1, 0, 32'h500);
    check("t6_pend_set", {31'd0, redirect_pend_o}, 32'd1);
    stall_i = 1;
    #3 rst = 1'b1;
    model_reset();
    #1 check_all("t6_async");
    #10 rst = 1'b0;
    stall_i = 0; branch_flag_i = 0;
    cycle("t6_e1", 0, 0, 0, 0, 0);
    check("t6_restart", pc_o, 32'h0);
    cycle("t6_e2", 0, 0, 0, 0, 0);
    check("t6_next", pc_o, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
